// File: rtl/bomb_slot_controller.sv
// Bomb slot pool: each slot runs FUSE -> BLINK -> BLAST -> IDLE on frame ticks, and all
// visible bombs share one bitmap through a lowest-index-wins hit test.
module bomb_slot_controller #(
    parameter int unsigned NUM_BOMBS    = 4,
    parameter int unsigned FUSE_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter int unsigned BLAST_FRAMES = 20,
    parameter int unsigned OBJECT_SIZE  = 32
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    placeRequest,
    input  logic [10:0]             placeX,
    input  logic [10:0]             placeY,
    input  logic                    detonateRequest,
    input  logic [10:0]             detonateX,
    input  logic [10:0]             detonateY,
    input  logic [10:0]             pixelX,
    input  logic [10:0]             pixelY,
    output logic                    placeAck,
    output logic                    placeReject,
    output logic [10:0]             bitmapOffsetX,
    output logic [10:0]             bitmapOffsetY,
    output logic                    bitmapInside,
    output logic [NUM_BOMBS-1:0]    blastStart,
    output logic [NUM_BOMBS-1:0]    blastActive,
    output logic [11*NUM_BOMBS-1:0] bombX,
    output logic [11*NUM_BOMBS-1:0] bombY,
    output logic [3:0]              activeCount
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFuse  = 2'd1;
    localparam logic [1:0] StBlink = 2'd2;
    localparam logic [1:0] StBlast = 2'd3;

    localparam logic [7:0]  FuseLast  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0]  BlinkLast = 8'(BLINK_FRAMES - 1);
    localparam logic [7:0]  BlastLast = 8'(BLAST_FRAMES - 1);
    localparam logic [11:0] ObjSize   = 12'(OBJECT_SIZE);

    logic [1:0]  state_q [NUM_BOMBS];
    logic [1:0]  state_d [NUM_BOMBS];
    logic [7:0]  cnt_q   [NUM_BOMBS];
    logic [7:0]  cnt_d   [NUM_BOMBS];
    logic [10:0] pos_x_q [NUM_BOMBS];
    logic [10:0] pos_x_d [NUM_BOMBS];
    logic [10:0] pos_y_q [NUM_BOMBS];
    logic [10:0] pos_y_d [NUM_BOMBS];

    logic [NUM_BOMBS-1:0] blast_start_d, blast_start_q;
    logic [NUM_BOMBS-1:0] place_sel;
    logic                 place_dup, place_free, place_ok;
    logic                 place_ack_q, place_reject_q;
    logic                 inside_d, inside_q;
    logic [10:0]          off_x_d, off_x_q, off_y_d, off_y_q;

    function automatic logic is_last(input logic [1:0] st, input logic [7:0] cnt);
        case (st)
            StFuse:  is_last = (cnt == FuseLast);
            StBlink: is_last = (cnt == BlinkLast);
            StBlast: is_last = (cnt == BlastLast);
            default: is_last = 1'b0;
        endcase
    endfunction

    // 12-bit compare keeps bombs near the 2047 edge from wrapping back to column 0.
    function automatic logic slot_hit(input logic [1:0] st, input logic [7:0] cnt,
                                      input logic [10:0] bx, input logic [10:0] by,
                                      input logic [10:0] px, input logic [10:0] py);
        logic visible, in_x, in_y;
        visible = (st == StFuse) || ((st == StBlink) && !cnt[2]);
        in_x    = ({1'b0, px} >= {1'b0, bx}) && ({1'b0, px} < ({1'b0, bx} + ObjSize));
        in_y    = ({1'b0, py} >= {1'b0, by}) && ({1'b0, py} < ({1'b0, by} + ObjSize));
        slot_hit = visible && in_x && in_y;
    endfunction

    always_comb begin
        place_sel  = '0;
        place_dup  = 1'b0;
        place_free = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (state_q[i] != StIdle && pos_x_q[i] == placeX && pos_y_q[i] == placeY) begin
                place_dup = 1'b1;
            end
            if (state_q[i] == StIdle && !place_free) begin
                place_sel[i] = 1'b1;
                place_free   = 1'b1;
            end
        end
        place_ok = placeRequest && place_free && !place_dup;
        if (!place_ok) begin
            place_sel = '0;
        end
    end

    // Placement only targets IDLE slots, so it never collides with detonation or ticking.
    always_comb begin
        blast_start_d = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pos_x_d[i] = pos_x_q[i];
            pos_y_d[i] = pos_y_q[i];
            if (place_sel[i]) begin
                state_d[i] = StFuse;
                cnt_d[i]   = 8'd0;
                pos_x_d[i] = placeX;
                pos_y_d[i] = placeY;
            end else if (detonateRequest && (state_q[i] == StFuse || state_q[i] == StBlink) &&
                         pos_x_q[i] == detonateX && pos_y_q[i] == detonateY) begin
                state_d[i]       = StBlast;
                cnt_d[i]         = 8'd0;
                blast_start_d[i] = 1'b1;
            end else if (startOfFrame && state_q[i] != StIdle) begin
                if (is_last(state_q[i], cnt_q[i])) begin
                    cnt_d[i] = 8'd0;
                    case (state_q[i])
                        StFuse:  state_d[i] = StBlink;
                        StBlink: begin
                            state_d[i]       = StBlast;
                            blast_start_d[i] = 1'b1;
                        end
                        default: state_d[i] = StIdle;
                    endcase
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        inside_d = 1'b0;
        off_x_d  = '0;
        off_y_d  = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (!inside_d &&
                slot_hit(state_q[i], cnt_q[i], pos_x_q[i], pos_y_q[i], pixelX, pixelY)) begin
                inside_d = 1'b1;
                off_x_d  = pixelX - pos_x_q[i];
                off_y_d  = pixelY - pos_y_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= 8'd0;
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
            end
            blast_start_q  <= '0;
            place_ack_q    <= 1'b0;
            place_reject_q <= 1'b0;
            inside_q       <= 1'b0;
            off_x_q        <= '0;
            off_y_q        <= '0;
        end else begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                pos_x_q[i] <= pos_x_d[i];
                pos_y_q[i] <= pos_y_d[i];
            end
            blast_start_q  <= blast_start_d;
            place_ack_q    <= place_ok;
            place_reject_q <= placeRequest && !place_ok;
            inside_q       <= inside_d;
            off_x_q        <= off_x_d;
            off_y_q        <= off_y_d;
        end
    end

    always_comb begin
        blastActive = '0;
        bombX       = '0;
        bombY       = '0;
        activeCount = 4'd0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            blastActive[i]    = (state_q[i] == StBlast);
            bombX[11*i +: 11] = pos_x_q[i];
            bombY[11*i +: 11] = pos_y_q[i];
            if (state_q[i] != StIdle) begin
                activeCount = activeCount + 4'd1;
            end
        end
    end

    assign placeAck      = place_ack_q;
    assign placeReject   = place_reject_q;
    assign blastStart    = blast_start_q;
    assign bitmapInside  = inside_q;
    assign bitmapOffsetX = off_x_q;
    assign bitmapOffsetY = off_y_q;

endmodule

// File: tb/tb_bomb_slot_controller.sv
// Random and directed stimulus for bomb_slot_controller, checked every cycle against a
// frame-age model of the slot pool.
module tb_bomb_slot_controller;

    localparam int NB    = 4;
    localparam int FUSE  = 120;
    localparam int BLINK = 32;
    localparam int BLAST = 20;
    localparam int OBJ   = 32;

    logic clk = 1'b0;
    logic resetN;
    logic startOfFrame, placeRequest, detonateRequest;
    logic [10:0] placeX, placeY, detonateX, detonateY, pixelX, pixelY;
    logic placeAck, placeReject, bitmapInside;
    logic [10:0] bitmapOffsetX, bitmapOffsetY;
    logic [NB-1:0] blastStart, blastActive;
    logic [11*NB-1:0] bombX, bombY;
    logic [3:0] activeCount;

    always #5 clk = ~clk;

    bomb_slot_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .placeRequest(placeRequest), .placeX(placeX), .placeY(placeY),
        .detonateRequest(detonateRequest), .detonateX(detonateX), .detonateY(detonateY),
        .pixelX(pixelX), .pixelY(pixelY), .placeAck(placeAck), .placeReject(placeReject),
        .bitmapOffsetX(bitmapOffsetX), .bitmapOffsetY(bitmapOffsetY),
        .bitmapInside(bitmapInside), .blastStart(blastStart), .blastActive(blastActive),
        .bombX(bombX), .bombY(bombY), .activeCount(activeCount)
    );

    // Model: phase 0 idle, 1 fuse, 2 blink, 3 blast; age = frames spent in the phase.
    int m_phase[NB];
    int m_age[NB];
    int m_x[NB];
    int m_y[NB];
    logic exp_ack, exp_rej, exp_inside;
    logic [NB-1:0] exp_bs;
    int exp_ox, exp_oy;
    int n_checks = 0;
    int n_fail = 0;

    int pool_x[6] = '{0, 16, 64, 2030, 100, 200};
    int pool_y[6] = '{0, 0, 96, 2040, 100, 50};

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int limit_of(input int ph);
        case (ph)
            1:       return FUSE;
            2:       return BLINK;
            default: return BLAST;
        endcase
    endfunction

    function automatic bit visible(input int i);
        return m_phase[i] == 1 || (m_phase[i] == 2 && ((m_age[i] / 4) % 2) == 0);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_phase[i] = 0;
            m_age[i]   = 0;
            m_x[i]     = 0;
            m_y[i]     = 0;
        end
        exp_ack = 0; exp_rej = 0; exp_inside = 0; exp_bs = '0; exp_ox = 0; exp_oy = 0;
    endfunction

    function automatic void model_step();
        int px, py, free_slot;
        bit dup;
        px = int'(pixelX);
        py = int'(pixelY);
        exp_inside = 0; exp_ox = 0; exp_oy = 0;
        for (int i = 0; i < NB; i++) begin
            if (!exp_inside && visible(i) && px >= m_x[i] && px < m_x[i] + OBJ &&
                py >= m_y[i] && py < m_y[i] + OBJ) begin
                exp_inside = 1;
                exp_ox = px - m_x[i];
                exp_oy = py - m_y[i];
            end
        end
        free_slot = -1;
        dup = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_phase[i] != 0 && m_x[i] == int'(placeX) && m_y[i] == int'(placeY)) dup = 1;
            if (m_phase[i] == 0 && free_slot < 0) free_slot = i;
        end
        exp_ack = placeRequest && free_slot >= 0 && !dup;
        exp_rej = placeRequest && !exp_ack;
        exp_bs = '0;
        for (int i = 0; i < NB; i++) begin
            if (exp_ack && i == free_slot) begin
                m_phase[i] = 1;
                m_age[i]   = 0;
                m_x[i]     = int'(placeX);
                m_y[i]     = int'(placeY);
            end else if (detonateRequest && (m_phase[i] == 1 || m_phase[i] == 2) &&
                         m_x[i] == int'(detonateX) && m_y[i] == int'(detonateY)) begin
                m_phase[i] = 3;
                m_age[i]   = 0;
                exp_bs[i]  = 1'b1;
            end else if (startOfFrame && m_phase[i] != 0) begin
                m_age[i]++;
                if (m_age[i] == limit_of(m_phase[i])) begin
                    m_age[i]   = 0;
                    m_phase[i] = (m_phase[i] + 1) % 4;
                    if (m_phase[i] == 3) exp_bs[i] = 1'b1;
                end
            end
        end
    endfunction

    task automatic compare_all();
        int act;
        check_value("place_ack", placeAck, exp_ack);
        check_value("place_reject", placeReject, exp_rej);
        check_value("blast_start", blastStart, exp_bs);
        check_value("bitmap_inside", bitmapInside, exp_inside);
        check_value("offset_x", bitmapOffsetX, exp_ox);
        check_value("offset_y", bitmapOffsetY, exp_oy);
        act = 0;
        for (int i = 0; i < NB; i++) begin
            if (m_phase[i] != 0) begin
                act++;
                check_value($sformatf("bomb_x%0d", i), bombX[11*i +: 11], m_x[i]);
                check_value($sformatf("bomb_y%0d", i), bombY[11*i +: 11], m_y[i]);
            end
            check_value($sformatf("blast_active%0d", i), blastActive[i], m_phase[i] == 3);
        end
        check_value("active_count", activeCount, act);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        placeRequest = 0;
        detonateRequest = 0;
        startOfFrame = 0;
    endtask

    task automatic place(input int x, input int y);
        placeRequest = 1;
        placeX = 11'(x);
        placeY = 11'(y);
    endtask

    task automatic set_pixel(input int x, input int y);
        pixelX = 11'(x);
        pixelY = 11'(y);
    endtask

    // Asserts reset between clock edges and checks that outputs clear without a clock.
    task automatic async_reset();
        #2 resetN = 0;
        #1;
        model_reset();
        compare_all();
        check_value("rst_bomb_x", bombX, 0);
        check_value("rst_inside", bitmapInside, 0);
        @(posedge clk);
        #1 resetN = 1;
    endtask

    initial begin
        int k, v;
        resetN = 0;
        startOfFrame = 0; placeRequest = 0; detonateRequest = 0;
        placeX = 0; placeY = 0; detonateX = 0; detonateY = 0; pixelX = 0; pixelY = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_value("rst_active_count", activeCount, 0);
        resetN = 1;

        place(64, 96);
        cycle();
        check_value("first_ack", placeAck, 1);
        set_pixel(70, 100);
        cycle();
        check_value("hit_inside", bitmapInside, 1);
        check_value("hit_off_x", bitmapOffsetX, 6);
        check_value("hit_off_y", bitmapOffsetY, 4);
        set_pixel(96, 96);
        cycle();
        check_value("edge_miss", bitmapInside, 0);

        place(0, 0);     cycle();
        place(16, 0);    cycle();
        place(300, 300); cycle();
        place(400, 400); cycle();
        check_value("full_reject", placeReject, 1);
        set_pixel(20, 5);
        cycle();
        check_value("overlap_off_x", bitmapOffsetX, 20);
        detonateRequest = 1; detonateX = 0; detonateY = 0; startOfFrame = 1;
        cycle();
        check_value("det_blast_start", blastStart, 4'b0010);
        cycle();
        check_value("after_det_off_x", bitmapOffsetX, 4);
        check_value("after_det_off_y", bitmapOffsetY, 5);

        for (int n = 0; n < 4000; n++) begin
            startOfFrame = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, 5);
                place(pool_x[k], pool_y[k]);
            end
            if ($urandom_range(0, 39) == 0) begin
                k = $urandom_range(0, 5);
                detonateRequest = 1;
                detonateX = 11'(pool_x[k]);
                detonateY = 11'(pool_y[k]);
            end
            k = $urandom_range(0, 5);
            v = pool_x[k] + int'($urandom_range(0, 47)) - 8;
            pixelX = 11'((v < 0) ? 0 : ((v > 2047) ? 2047 : v));
            v = pool_y[k] + int'($urandom_range(0, 47)) - 8;
            pixelY = 11'((v < 0) ? 0 : ((v > 2047) ? 2047 : v));
            cycle();
        end

        async_reset();
        place(500, 500);
        cycle();
        set_pixel(510, 510);
        for (int n = 0; n < FUSE + 2; n++) begin
            startOfFrame = 1;
            cycle();
        end
        check_value("blink_visible", bitmapInside, 1);
        async_reset();
        place(700, 700);
        cycle();
        check_value("post_rst_ack", placeAck, 1);
        check_value("post_rst_slot0", bombX[10:0], 700);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bomb_slot_controller.md
# bomb_slot_controller

Bomb lifecycle controller and render arbiter for the bomb sprite path. Owns a fixed pool of bomb slots and sequences each one through fuse, blink, blast and free. Shares the single 32x32 bomb bitmap between all live bombs by producing its per-pixel offset and inside-rectangle inputs. Sits between the player/game-logic request side and the bomb bitmap, and hands blast events to the explosion logic.

## Interface
Parameters:
- NUM_BOMBS, 4, number of slots (1..8)
- FUSE_FRAMES, 120, frames spent in FUSE
- BLINK_FRAMES, 32, frames spent in BLINK
- BLAST_FRAMES, 20, frames spent in BLAST
- OBJECT_SIZE, 32, sprite edge in pixels (power of 2)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle frame tick
- placeRequest  in  1  one-cycle request to place a bomb
- placeX, placeY  in  11 each  top-left of requested bomb
- detonateRequest  in  1  one-cycle chain-detonation request
- detonateX, detonateY  in  11 each  position to detonate
- pixelX, pixelY  in  11 each  current VGA pixel
- placeAck  out  1  one-cycle, placement accepted
- placeReject  out  1  one-cycle, placement refused
- bitmapOffsetX, bitmapOffsetY  out  11 each  offset into bitmap
- bitmapInside  out  1  pixel inside a visible bomb
- blastStart  out  NUM_BOMBS  one-cycle pulse per slot entering BLAST
- blastActive  out  NUM_BOMBS  slot currently in BLAST
- bombX, bombY  out  11*NUM_BOMBS each  packed slot positions (slot i at bits [11i+10:11i])
- activeCount  out  4  slots not in IDLE

## Operation
- Each slot has a state (IDLE, FUSE, BLINK, BLAST), an 8-bit frame counter, and a registered position.
- Placement is evaluated on the cycle placeRequest=1.
  - Accepted if at least one IDLE slot exists and no non-IDLE slot holds an identical (placeX, placeY).
  - The lowest-index IDLE slot takes the position, enters FUSE, and its counter is cleared.
  - Otherwise placeReject pulses.
- On each startOfFrame, every non-IDLE slot increments its counter. When counter reaches limit-1, the slot advances and the counter clears:
  - FUSE→BLINK after FUSE_FRAMES ticks.
  - BLINK→BLAST after BLINK_FRAMES ticks.
  - BLAST→IDLE after BLAST_FRAMES ticks.
- Detonation: on detonateRequest, every slot in FUSE or BLINK whose position equals (detonateX, detonateY) enters BLAST with its counter cleared. IDLE and BLAST slots are unaffected.
- blastStart[i] pulses for exactly one cycle on every entry to BLAST, whether from timeout or detonation.
- Visibility:
  - FUSE: always visible.
  - BLINK: visible when counter[2]==0 (4 frames on, 4 frames off).
  - BLAST and IDLE: never visible.
- Hit test: a pixel hits slot i when bombX ≤ pixelX < bombX+OBJECT_SIZE and bombY ≤ pixelY < bombY+OBJECT_SIZE.
  - Compare at 12 bits so no wrap-around occurs near 2047.
  - Among visible hits, the lowest index wins.
  - bitmapOffsetX/Y = pixel − winner position; zero when there is no hit.
- Simultaneous events:
  - Placement and startOfFrame in the same cycle: the new slot starts with counter 0 and ignores that tick.
  - Detonation and startOfFrame in the same cycle: detonation wins (counter 0 in BLAST).
  - Placement and detonation at the same position in the same cycle: detonation is evaluated against pre-cycle state, so the new bomb is not detonated.
  - A slot completing BLAST→IDLE in the same cycle as a placement is not yet free; the placement uses another slot or is rejected.

## Timing
- Reset values: all slots IDLE, counters 0, positions 0; all outputs 0.
- placeAck/placeReject: registered, asserted the cycle after placeRequest, width one cycle.
- Slot state, counter and blastStart update one cycle after the triggering startOfFrame or detonateRequest edge.
- Pixel path: one register stage.
  - bitmapInside and bitmapOffsetX/Y correspond to pixelX/Y of the previous cycle.
  - Visibility uses slot state as of that cycle.
  - The bitmap adds its own stage, giving 2 cycles total pixel→RGB.
- activeCount, blastActive and bombX/Y are registered copies of slot state, with no extra latency beyond the state register.
- Reset asserted mid-operation clears all slots immediately. No blastStart is emitted for slots killed by reset.

## Test plan
- Place at (64,96) → placeAck next cycle, slot0 FUSE, activeCount=1. Pixel (70,100) → one cycle later bitmapInside=1, offset=(6,4). Pixel (96,96) → bitmapInside=0.
- Place 4 distinct positions, then a 5th → 5th gets placeReject. Repeat an existing position with a slot free → placeReject.
- Single bomb, 120 ticks → BLINK; bitmapInside alternates every 4 frames. After 32 more ticks, blastStart[0] pulses once and blastActive[0]=1. After 20 more ticks, IDLE and activeCount=0.
- Bombs at (0,0) and (16,0) overlapping; pixel (20,5) → offset (20,5) from slot0. After slot0 detonates, a later pixel (20,5) → offset (4,5) from slot1.
- detonateRequest at slot1's position concurrent with startOfFrame → blastStart[1] next cycle, counter 0, other slots unchanged.
- Assert resetN=0 mid-BLINK → all outputs 0 asynchronously; after release, a placement succeeds into slot0.
